// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic helpers and Chien-search sizing shared by the RS decoder slice.
//   symb_t           : one field symbol
//   gf_mult          : general carry-less multiply reduced by GF_POLY
//   gf_const_mult    : a * alpha^e
//   alpha_to_symb    : alpha^e as a symbol
//   neg_exp          : exponent of alpha^(-e) in 0..GF_ORDER-1
//   chien_cycles     : ceil(n / r), search length in cycles
package gf_pkg;

    localparam int unsigned GF_M     = 8;
    localparam int unsigned GF_ORDER = (1 << GF_M) - 1;
    localparam logic [GF_M:0] GF_POLY = 9'h11D;

    typedef logic [GF_M-1:0] symb_t;

    function automatic symb_t gf_xtime(symb_t a);
        symb_t r;
        r = {a[GF_M-2:0], 1'b0};
        if (a[GF_M-1]) r = r ^ GF_POLY[GF_M-1:0];
        return r;
    endfunction

    function automatic symb_t gf_mult(symb_t a, symb_t b);
        symb_t acc;
        symb_t sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < GF_M; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    // Square-and-multiply keeps constant evaluation short for any exponent.
    function automatic symb_t alpha_to_symb(int unsigned e);
        int unsigned ee;
        symb_t       res;
        symb_t       base;
        ee   = e % GF_ORDER;
        res  = symb_t'(1);
        base = symb_t'(2);
        for (int i = 0; i < GF_M; i++) begin
            if (ee[i]) res = gf_mult(res, base);
            base = gf_mult(base, base);
        end
        return res;
    endfunction

    function automatic int unsigned neg_exp(int unsigned e);
        return (GF_ORDER - (e % GF_ORDER)) % GF_ORDER;
    endfunction

    function automatic symb_t gf_const_mult(symb_t a, int unsigned e);
        return gf_mult(a, alpha_to_symb(e));
    endfunction

    function automatic int unsigned chien_cycles(int unsigned n, int unsigned r);
        return (n + r - 1) / r;
    endfunction

    localparam int unsigned CHIEN_N_LEN      = 255;
    localparam int unsigned CHIEN_R          = 16;
    localparam int unsigned CHIEN_CYCLES     = chien_cycles(CHIEN_N_LEN, CHIEN_R);
    localparam int unsigned CHIEN_LAST_LANES = CHIEN_N_LEN - (CHIEN_CYCLES - 1) * CHIEN_R;

endpackage

// File: rtl/rs_chien_search_if.sv
// Handshake bundle between key-equation solver, Chien search and Forney stage.
//   sigma/sigma_vld/sigma_rdy : locator polynomial in (index k = x^k coefficient)
//   err_pos/err_cnt/dec_fail  : result out, qualified by res_vld/res_rdy
interface rs_chien_search_if #(
    parameter int unsigned SYMB_WIDTH = 8,
    parameter int unsigned T_LEN      = 8,
    parameter int unsigned N_LEN      = 255
);
    localparam int unsigned CntW = $clog2(N_LEN + 1);

    logic [T_LEN:0][SYMB_WIDTH-1:0]   sigma;
    logic                             sigma_vld;
    logic                             sigma_rdy;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] err_pos;
    logic [CntW-1:0]                  err_cnt;
    logic                             dec_fail;
    logic                             res_vld;
    logic                             res_rdy;

    modport slave (
        input  sigma, sigma_vld, res_rdy,
        output sigma_rdy, err_pos, err_cnt, dec_fail, res_vld
    );

    modport master (
        output sigma, sigma_vld, res_rdy,
        input  sigma_rdy, err_pos, err_cnt, dec_fail, res_vld
    );
endinterface

// File: rtl/rs_chien_eval_slice.sv
// Combinational evaluation of ROOTS_PER_CYCLE lanes: lane r computes
// XOR_k term_k * alpha^(-k*r) and flags a root when the sum is zero.
//   term_i : current scaled locator terms
//   root_o : one bit per lane, set when that lane's sum is zero
module rs_chien_eval_slice
    import gf_pkg::*;
#(
    parameter int unsigned T_LEN           = 8,
    parameter int unsigned ROOTS_PER_CYCLE = 16
) (
    input  symb_t [T_LEN:0]             term_i,
    output logic  [ROOTS_PER_CYCLE-1:0] root_o
);

    for (genvar r = 0; r < ROOTS_PER_CYCLE; r++) begin : g_lane
        symb_t prod [T_LEN+1];
        symb_t sum;

        for (genvar k = 0; k <= T_LEN; k++) begin : g_term
            localparam symb_t Coef = alpha_to_symb(neg_exp(k * r));
            assign prod[k] = gf_mult(term_i[k], Coef);
        end

        always_comb begin
            sum = '0;
            for (int k = 0; k <= T_LEN; k++) sum = sum ^ prod[k];
        end

        assign root_o[r] = (sum == '0);
    end

endmodule

// File: rtl/rs_chien_search.sv
// Chien search: evaluates sigma(x) at alpha^(-p) for p = 0..N_LEN-1, R positions per cycle,
// and returns ascending error positions, error count and a decode-failure flag.
//   aclk, aresetn : clock, asynchronous active-low reset
//   bus_io        : sigma in / result out handshake bundle (slave side)
module rs_chien_search
    import gf_pkg::*;
#(
    parameter int unsigned SYMB_WIDTH      = 8,
    parameter int unsigned T_LEN           = 8,
    parameter int unsigned N_LEN           = 255,
    parameter int unsigned ROOTS_PER_CYCLE = 16
) (
    input logic               aclk,
    input logic               aresetn,
    rs_chien_search_if.slave  bus_io
);

    localparam int unsigned R         = ROOTS_PER_CYCLE;
    localparam int unsigned Cyc       = chien_cycles(N_LEN, R);
    localparam int unsigned LastLanes = N_LEN - (Cyc - 1) * R;
    localparam int unsigned CntW      = $clog2(N_LEN + 1);
    localparam int unsigned CycW      = $clog2(Cyc + 1);
    localparam int unsigned DegW      = $clog2(T_LEN + 1);

    typedef enum logic [1:0] {StIdle, StSearch, StFlush, StHold} state_e;

    state_e                           state_q;
    symb_t [T_LEN:0]                  term_q;
    symb_t [T_LEN:0]                  term_step;
    logic [CycW-1:0]                  cyc_q;
    logic [R-1:0]                     root_raw, root_masked, stage_root_q;
    logic [CntW-1:0]                  stage_base_q;
    logic                             stage_vld_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] col_pos_q, col_pos_d;
    logic [CntW-1:0]                  col_cnt_q, col_cnt_d;
    logic [DegW-1:0]                  deg_q, deg_in;
    logic                             sig0_zero_q;
    logic [T_LEN-1:0][SYMB_WIDTH-1:0] err_pos_q;
    logic [CntW-1:0]                  err_cnt_q;
    logic                             dec_fail_q, dec_fail_d;
    logic                             res_vld_q, sigma_rdy_q;
    logic                             last_cyc;

    // Advance every term by alpha^(-k*R) so the next cycle covers the next R positions.
    for (genvar k = 0; k <= T_LEN; k++) begin : g_step
        localparam symb_t Step = alpha_to_symb(neg_exp(k * R));
        assign term_step[k] = gf_mult(term_q[k], Step);
    end

    rs_chien_eval_slice #(
        .T_LEN           (T_LEN),
        .ROOTS_PER_CYCLE (R)
    ) u_eval (
        .term_i (term_q),
        .root_o (root_raw)
    );

    assign last_cyc = (int'(cyc_q) == int'(Cyc) - 1);

    always_comb begin
        for (int r = 0; r < R; r++) begin
            root_masked[r] = root_raw[r] & (!last_cyc || (r < LastLanes));
        end
    end

    always_comb begin
        deg_in = '0;
        for (int k = 0; k <= T_LEN; k++) begin
            if (bus_io.sigma[k] != '0) deg_in = DegW'(k);
        end
    end

    // Append roots in lane order; positions beyond T_LEN slots are only counted.
    always_comb begin
        col_pos_d = col_pos_q;
        col_cnt_d = col_cnt_q;
        for (int r = 0; r < R; r++) begin
            if (stage_root_q[r]) begin
                for (int s = 0; s < T_LEN; s++) begin
                    if (int'(col_cnt_d) == s) col_pos_d[s] = SYMB_WIDTH'(int'(stage_base_q) + r);
                end
                if (int'(col_cnt_d) < int'(N_LEN)) col_cnt_d = col_cnt_d + 1'b1;
            end
        end
    end

    assign dec_fail_d = sig0_zero_q || (int'(col_cnt_d) != int'(deg_q)) ||
                        (int'(col_cnt_d) > int'(T_LEN));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= StIdle;
            term_q       <= '0;
            cyc_q        <= '0;
            stage_root_q <= '0;
            stage_base_q <= '0;
            stage_vld_q  <= 1'b0;
            col_pos_q    <= '0;
            col_cnt_q    <= '0;
            deg_q        <= '0;
            sig0_zero_q  <= 1'b0;
            err_pos_q    <= '0;
            err_cnt_q    <= '0;
            dec_fail_q   <= 1'b0;
            res_vld_q    <= 1'b0;
            sigma_rdy_q  <= 1'b1;
        end else begin
            stage_vld_q <= 1'b0;
            if (stage_vld_q) begin
                col_pos_q <= col_pos_d;
                col_cnt_q <= col_cnt_d;
            end
            unique case (state_q)
                StIdle: begin
                    if (bus_io.sigma_vld) begin
                        term_q      <= bus_io.sigma;
                        deg_q       <= deg_in;
                        sig0_zero_q <= (bus_io.sigma[0] == '0);
                        col_pos_q   <= '0;
                        col_cnt_q   <= '0;
                        cyc_q       <= '0;
                        sigma_rdy_q <= 1'b0;
                        state_q     <= StSearch;
                    end
                end
                StSearch: begin
                    term_q       <= term_step;
                    stage_root_q <= root_masked;
                    stage_base_q <= CntW'(int'(cyc_q) * int'(R));
                    stage_vld_q  <= 1'b1;
                    if (last_cyc) state_q <= StFlush;
                    else          cyc_q   <= cyc_q + 1'b1;
                end
                StFlush: begin
                    err_pos_q  <= col_pos_d;
                    err_cnt_q  <= col_cnt_d;
                    dec_fail_q <= dec_fail_d;
                    res_vld_q  <= 1'b1;
                    state_q    <= StHold;
                end
                StHold: begin
                    if (bus_io.res_rdy) begin
                        res_vld_q   <= 1'b0;
                        sigma_rdy_q <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.sigma_rdy = sigma_rdy_q;
    assign bus_io.res_vld   = res_vld_q;
    assign bus_io.err_pos   = err_pos_q;
    assign bus_io.err_cnt   = err_cnt_q;
    assign bus_io.dec_fail  = dec_fail_q;

endmodule

// File: tb/tb_rs_chien_search.sv
// Bench for rs_chien_search: two instances (full N=255 and shortened N=204, R=16)
// checked against a log/antilog-table polynomial evaluator.
module tb_rs_chien_search;

    typedef logic [8:0][7:0] sig_t;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    rs_chien_search_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255)) if_a ();
    rs_chien_search_if #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(204)) if_b ();

    rs_chien_search #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(255), .ROOTS_PER_CYCLE(16)) dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus_io  (if_a)
    );

    rs_chien_search #(.SYMB_WIDTH(8), .T_LEN(8), .N_LEN(204), .ROOTS_PER_CYCLE(16)) dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus_io  (if_b)
    );

    logic sel = 1'b0;
    sig_t sig_drv = '0;
    logic vld_drv = 1'b0;
    logic rdy_drv = 1'b0;

    assign if_a.sigma     = sig_drv;
    assign if_b.sigma     = sig_drv;
    assign if_a.sigma_vld = vld_drv & ~sel;
    assign if_b.sigma_vld = vld_drv & sel;
    assign if_a.res_rdy   = rdy_drv & ~sel;
    assign if_b.res_rdy   = rdy_drv & sel;

    logic            m_rdy, m_vld, m_fail;
    logic [7:0]      m_cnt;
    logic [7:0][7:0] m_pos;
    assign m_rdy  = sel ? if_b.sigma_rdy : if_a.sigma_rdy;
    assign m_vld  = sel ? if_b.res_vld   : if_a.res_vld;
    assign m_fail = sel ? if_b.dec_fail  : if_a.dec_fail;
    assign m_cnt  = sel ? if_b.err_cnt   : if_a.err_cnt;
    assign m_pos  = sel ? if_b.err_pos   : if_a.err_pos;

    int n_vec = 0;
    int n_err = 0;
    int exp_t [0:254];
    int log_t [0:255];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic int gmul(int a, int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % 255];
    endfunction

    // Direct Horner evaluation of sigma at alpha^(-p) for every position.
    task automatic ref_model(input sig_t s, input int n, output int pos[8], output int cnt,
                             output bit fail);
        int deg;
        int x;
        int v;
        deg = 0;
        for (int k = 0; k <= 8; k++) if (s[k] != 0) deg = k;
        cnt = 0;
        for (int i = 0; i < 8; i++) pos[i] = 0;
        for (int p = 0; p < n; p++) begin
            x = exp_t[(255 - p % 255) % 255];
            v = 0;
            for (int k = 8; k >= 0; k--) v = gmul(v, x) ^ int'(s[k]);
            if (v == 0) begin
                if (cnt < 8) pos[cnt] = p;
                cnt++;
            end
        end
        fail = (s[0] == 0) || (cnt != deg) || (cnt > 8);
    endtask

    // Product of (1 + alpha^q x) over distinct random q, scaled; occasionally fully random.
    task automatic rand_sigma(output sig_t s);
        int c[9];
        int q[8];
        int ne;
        int sc;
        bit dup;
        if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k <= 8; k++) s[k] = 8'($urandom);
            return;
        end
        ne = int'($urandom_range(0, 8));
        for (int k = 0; k <= 8; k++) c[k] = 0;
        c[0] = 1;
        for (int i = 0; i < ne; i++) begin
            do begin
                q[i] = int'($urandom_range(0, 254));
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (q[j] == q[i]) dup = 1'b1;
            end while (dup);
            for (int j = 8; j >= 1; j--) c[j] = c[j] ^ gmul(exp_t[q[i]], c[j-1]);
        end
        sc = int'($urandom_range(1, 255));
        for (int k = 0; k <= 8; k++) s[k] = 8'(gmul(c[k], sc));
    endtask

    // Entered and left on a negative edge.
    task automatic run_txn(input logic which, input sig_t s, input int hold);
        int n;
        int cyc;
        int w;
        int lat;
        int pos[8];
        int cnt;
        bit fail;
        n   = which ? 204 : 255;
        cyc = (n + 15) / 16;
        ref_model(s, n, pos, cnt, fail);
        sel     = which;
        sig_drv = s;
        vld_drv = 1'b1;
        w = 0;
        while (!m_rdy && w < 50) begin
            @(negedge aclk);
            w++;
        end
        check_val("sigma_rdy_idle", m_rdy, 1);
        @(posedge aclk);
        @(negedge aclk);
        vld_drv = 1'b0;
        lat = 1;
        check_val("sigma_rdy_busy", m_rdy, 0);
        while (!m_vld && lat < cyc + 10) begin
            @(negedge aclk);
            lat++;
        end
        check_val("latency", lat, cyc + 2);
        check_val("err_cnt", m_cnt, (cnt > 255) ? 255 : cnt);
        check_val("dec_fail", m_fail, fail);
        for (int i = 0; i < 8; i++) check_val($sformatf("err_pos%0d", i), m_pos[i], pos[i]);
        if (hold > 0) begin
            repeat (hold) @(negedge aclk);
            check_val("hold_vld", m_vld, 1);
            check_val("hold_rdy", m_rdy, 0);
            check_val("hold_cnt", m_cnt, cnt);
            check_val("hold_pos0", m_pos[0], pos[0]);
        end
        rdy_drv = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        rdy_drv = 1'b0;
        check_val("post_hs_vld", m_vld, 0);
        check_val("post_hs_rdy", m_rdy, 1);
        check_val("post_hs_cnt", m_cnt, cnt);
        check_val("post_hs_fail", m_fail, fail);
    endtask

    initial begin
        sig_t s;
        int v;
        v = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = v;
            log_t[v] = i;
            v = v << 1;
            if ((v & 256) != 0) v = v ^ 'h11D;
        end
        log_t[0] = 0;

        repeat (3) @(negedge aclk);
        check_val("rst_rdy_a", if_a.sigma_rdy, 1);
        check_val("rst_rdy_b", if_b.sigma_rdy, 1);
        check_val("rst_vld", m_vld, 0);
        check_val("rst_cnt", m_cnt, 0);
        check_val("rst_fail", m_fail, 0);
        check_val("rst_pos", |m_pos, 0);
        aresetn = 1'b1;
        @(negedge aclk);

        s = '0; s[0] = 8'h01; s[1] = 8'h20;
        run_txn(1'b0, s, 0);
        s = '0; s[0] = 8'h01; s[1] = 8'h09; s[2] = 8'h08;
        run_txn(1'b0, s, 0);
        s = '0; s[0] = 8'h01; s[1] = 8'(exp_t[250]);
        run_txn(1'b1, s, 0);
        s = '0; s[0] = 8'h01; s[1] = 8'(exp_t[203]);
        run_txn(1'b1, s, 0);
        s = '0; s[0] = 8'h07;
        run_txn(1'b0, s, 0);
        s = '0;
        run_txn(1'b1, s, 0);
        s = '0; s[0] = 8'h01; s[1] = 8'h09; s[2] = 8'h08;
        run_txn(1'b0, s, 10);

        // Reset in the middle of a search.
        sel = 1'b0;
        s = '0; s[0] = 8'h01; s[1] = 8'h20;
        sig_drv = s;
        vld_drv = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        vld_drv = 1'b0;
        repeat (5) @(negedge aclk);
        check_val("pre_rst_busy", m_rdy, 0);
        #2 aresetn = 1'b0;
        #1;
        check_val("mid_rst_vld", m_vld, 0);
        check_val("mid_rst_rdy", m_rdy, 1);
        check_val("mid_rst_cnt", m_cnt, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        run_txn(1'b0, s, 0);

        for (int t = 0; t < 40; t++) begin
            rand_sigma(s);
            run_txn(1'(t % 2), s, int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rs_chien_search.md
Name: rs_chien_search

Overview:
- Parametrised, handshaked Chien search for RS decoders.
- Takes the error-locator polynomial sigma(x) from the key-equation solver and evaluates it at alpha^(-p) for every codeword position p in 0..N_LEN-1, R roots per cycle.
- Supports shortened codes.
- Returns an ascending list of error positions, the error count and a decode-failure flag to the Forney/correction stage.

Parameters:
- SYMB_WIDTH, 8: GF(2^m) symbol width; field and primitive polynomial come from gf_pkg.
- T_LEN, 8: correctable symbols; sigma has T_LEN+1 coefficients.
- N_LEN, 255: codeword length, 1..2^SYMB_WIDTH-1; values below 2^m-1 mean a shortened code.
- ROOTS_PER_CYCLE, 16: positions evaluated per cycle (R), 1..N_LEN.

Ports:
- aclk, in, 1: clock.
- aresetn, in, 1: reset, asynchronous, active-low.
- sigma, in, [SYMB_WIDTH-1:0] x (T_LEN+1): locator coefficients; index k is the x^k coefficient.
- sigma_vld, in, 1: sigma valid.
- sigma_rdy, out, 1: block can accept sigma.
- err_pos, out, [SYMB_WIDTH-1:0] x T_LEN: error positions, ascending; unused slots are 0.
- err_cnt, out, $clog2(N_LEN+1): number of roots found within 0..N_LEN-1.
- dec_fail, out, 1: uncorrectable block.
- res_vld, out, 1: result valid.
- res_rdy, in, 1: downstream accepts the result.

Behaviour:
- FSM states: IDLE, SEARCH, FLUSH, HOLD.
  - Reset: state IDLE; sigma_rdy=1; res_vld=0; err_pos all 0; err_cnt=0; dec_fail=0.
- IDLE: sigma_rdy=1. On sigma_vld&sigma_rdy:
  - latch term_k = sigma_k for all k;
  - compute deg = index of highest nonzero coefficient;
  - clear the collectors;
  - go to SEARCH.
- SEARCH: lasts CYC = ceil(N_LEN/R) cycles; cycle counter c runs 0..CYC-1.
  - Lane r (0..R-1) evaluates position p = c*R + r as S_r = XOR_k term_k * alpha^(-k*r), using constant multipliers.
  - After each cycle, term_k <= term_k * alpha^(-k*R).
  - Lane r is a root iff S_r == 0 and p < N_LEN. On the last cycle, lanes with p >= N_LEN are masked.
- Evaluation is registered one stage.
- FLUSH: one cycle that lets the last stage drain into the collectors. Then go to HOLD.
- Collector, applied each cycle in which the stage output is valid:
  - Root lanes are appended in ascending lane order to the first free err_pos slots.
  - At most T_LEN positions are stored; further roots are only counted.
  - err_cnt saturates at N_LEN.
- HOLD: res_vld=1; outputs stable until res_rdy.
  - On res_vld&res_rdy: return to IDLE; err_pos/err_cnt/dec_fail stay stable until the next result.
  - sigma_rdy=0 in SEARCH, FLUSH and HOLD (no overlap).
- Latency: sigma accepted at cycle 0 -> res_vld asserted at cycle CYC+2.
- dec_fail = 1 when any of the following holds:
  - sigma_0 == 0;
  - err_cnt != deg;
  - err_cnt > T_LEN.
  - Otherwise dec_fail = 0.
  - sigma all-zero: deg=0, sigma_0=0, so dec_fail=1.
- sigma = constant nonzero (deg 0): no roots, err_cnt=0, dec_fail=0 (error-free block).
- Arithmetic:
  - All GF operations are carry-less and reduced by the gf_pkg primitive polynomial.
  - alpha^(-e) is taken as alpha^((2^m-1-e) mod (2^m-1)).
  - Position p is a binary index, not a field element.
- sigma_vld while not ready is ignored; upstream must hold it.
- res_rdy while res_vld=0 has no effect.
- aresetn low mid-operation: immediately IDLE with reset outputs; no partial result is emitted.
- R=N_LEN: CYC=1, latency 3.
- R not dividing N_LEN: last-cycle masking as above.

Decomposition:
- gf_pkg holds:
  - gf_mult, gf_const_mult(a, e) returning a*alpha^e, and alpha_to_symb;
  - localparams CHIEN_CYCLES=ceil(N_LEN/R) and CHIEN_LAST_LANES=N_LEN-(CYC-1)*R, with CHIEN_CYCLES computed by a package function;
  - typedef symb_t.
- Sub-module rs_chien_eval_slice:
  - combinational evaluation of R lanes from term_k;
  - outputs an R-bit root vector.
- Top level holds the FSM, term registers, pipeline stage, collector and handshakes.

Test Plan:
- Field GF(2^8), poly 0x11D, N_LEN=255, R=16, T_LEN=8.
  - sigma=1+0x20x (alpha^5) -> at cycle 18: res_vld=1, err_pos[0]=5, err_cnt=1, dec_fail=0.
- Same field and configuration.
  - sigma=1+0x09x+0x08x^2 -> err_pos[0]=0, err_pos[1]=3, err_cnt=2, dec_fail=0; remaining slots 0.
- N_LEN=204, R=16 (CYC=13, masked lanes 12..15 on the last cycle).
  - sigma=1+alpha^250x (root at p=250) -> err_cnt=0, dec_fail=1.
  - sigma=1+alpha^203x -> err_pos[0]=203, dec_fail=0.
- sigma=0x07 (constant) -> err_cnt=0, dec_fail=0.
- sigma all zero -> dec_fail=1.
- Hold res_rdy=0 for 10 cycles after res_vld -> outputs stable, sigma_rdy=0; new sigma accepted only after the handshake.
- Deassert aresetn in the middle of SEARCH -> res_vld=0, sigma_rdy=1 asynchronously.
  - A following sigma (the first scenario) yields the correct result with the nominal latency.
